// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial add/subtract using one shared full adder, LSB first, with valid/ready handshakes

module full_adder (
  input  logic in1,
  input  logic in2,
  input  logic in3,
  output logic Sum,
  output logic Cout
);
  assign Sum  = in1 ^ in2 ^ in3;
  assign Cout = (in1 & in2) | (in3 & (in1 ^ in2));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a_r, b_r;
  logic [IW-1:0] idx;
  logic carry, fa_s, fa_co;
  full_adder u_fa (
    .in1 (a_r[idx]),
    .in2 (b_r[idx]),
    .in3 (carry),
    .Sum (fa_s),
    .Cout(fa_co)
  );
  // Subtraction is A + ~B + 1, so B is inverted at latch time and carry seeded with 1.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      idx       <= '0;
      carry     <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (in_valid) begin
            a_r      <= a;
            b_r      <= sub ? ~b : b;
            carry    <= sub ? 1'b1 : cin;
            idx      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        RUN: begin
          sum[idx] <= fa_s;
          carry    <= fa_co;
          if (idx == LAST) begin
            cout      <= fa_co;
            ovf       <= carry ^ fa_co;
            state     <= DONE;
            out_valid <= 1'b1;
          end else
            idx <= idx + 1'b1;
        end
        DONE:
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: randomized and directed checks of serial_adder_ctrl against an arithmetic reference model
module tb_serial_adder_ctrl;
  localparam int W = 8;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, cin = 0, sub = 0, out_valid, out_ready = 0, cout, ovf, busy;
  logic [W-1:0] a = '0, b = '0, sum;
  int n_cmp = 0, n_bad = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {ovf, cout, sum} from plain two's-complement arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, y, input logic c, s);
    logic [W:0] r;
    logic o;
    r = s ? {1'b0, x} + {1'b0, ~y} + (W+1)'(1) : {1'b0, x} + {1'b0, y} + (W+1)'(c);
    o = s ? (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]) : (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    return {o, r};
  endfunction

  task automatic run_op(input logic [W-1:0] ta, tb, input logic tc, ts, input int hold, input bit scramble);
    logic [W+1:0] e;
    int n;
    e = model(ta, tb, tc, ts);
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("idle_ready", in_ready, 1);
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1; out_ready = 0;
    @(posedge clk); #1;
    in_valid = 0;
    check("run_busy", busy, 1);
    check("run_in_ready", in_ready, 0);
    n = 0;
    while (!out_valid && n < 20) begin
      if (scramble) begin
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom); in_valid = 1'($urandom);
      end
      @(posedge clk); #1; n++;
    end
    in_valid = 0;
    check("latency", n, W);
    check("sum", sum, e[W-1:0]);
    check("cout", cout, e[W]);
    check("ovf", ovf, e[W+1]);
    check("done_in_ready", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_res", {ovf, cout, sum}, e);
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    check("ret_valid", out_valid, 0);
    check("ret_in_ready", in_ready, 1);
    check("ret_busy", busy, 0);
    check("ret_keep", {ovf, cout, sum}, e);
  endtask

  initial begin
    #12;
    check("rst_sum", sum, 0);
    check("rst_flags", {cout, ovf, out_valid, busy}, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk); rst_n = 1;
    run_op(8'h5A, 8'h3C, 0, 0, 0, 0);
    run_op(8'hFF, 8'h01, 0, 0, 0, 0);
    run_op(8'h00, 8'h00, 1, 0, 0, 0);
    run_op(8'h10, 8'h20, 1, 1, 0, 0);
    run_op(8'h80, 8'h01, 0, 1, 5, 0);
    run_op(8'h7F, 8'h00, 1, 0, 0, 1);
    // Reset mid-run, after bits 0..3 have been processed.
    a = 8'hC3; b = 8'h5E; cin = 1; sub = 0; in_valid = 1;
    @(posedge clk); #1; in_valid = 0;
    repeat (4) @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("mid_rst_sum", sum, 0);
    check("mid_rst_flags", {cout, ovf, out_valid, busy}, 0);
    check("mid_rst_in_ready", in_ready, 1);
    @(negedge clk); rst_n = 1;
    run_op(8'hC3, 8'h5E, 1, 0, 0, 0);
    for (int k = 0; k < 30; k++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  operand set presented.
REQ-005 SHALL have port in_ready  output  1  controller can accept operands.
REQ-006 SHALL have port a  input  WIDTH  operand A.
REQ-007 SHALL have port b  input  WIDTH  operand B.
REQ-008 SHALL have port cin  input  1  carry-in for add mode.
REQ-009 SHALL have port sub  input  1  0 = A+B+cin, 1 = A-B.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port sum  output  WIDTH  result bits.
REQ-013 SHALL have port cout  output  1  carry out of MSB; in sub mode 1 = no borrow.
REQ-014 SHALL have port ovf  output  1  signed two's-complement overflow.
REQ-015 SHALL have port busy  output  1  high in RUN or DONE.

Function
REQ-016 SHALL compute all result bits with exactly one instance of full_adder (ports in1, in2, in3, Sum, Cout), one bit per clock, LSB first.
REQ-017 SHALL implement FSM states IDLE, RUN, DONE.
REQ-018 SHALL drive in_ready high only in IDLE; out_valid high only in DONE.
REQ-019 SHALL, on a clock edge with in_valid && in_ready, latch a, b (inverted if sub), initial carry (cin if add, 1 if sub), clear bit index, enter RUN.
REQ-020 SHALL, on each RUN edge, write full_adder Sum into sum[index], register Cout as next carry, increment index.
REQ-021 SHALL, on the RUN edge processing bit WIDTH-1, set cout to that bit's Cout, ovf to carry-in XOR carry-out of bit WIDTH-1, enter DONE.
REQ-022 SHALL assert out_valid on the cycle after the WIDTH-th RUN edge: latency WIDTH cycles from acceptance edge.
REQ-023 SHALL hold sum, cout, ovf stable while out_valid high and out_ready low, for any number of cycles.
REQ-024 SHALL, on a DONE edge with out_ready high, return to IDLE; in_ready high the following cycle; no same-cycle bypass; throughput one op per WIDTH+2 cycles.
REQ-025 SHALL ignore in_valid, a, b, cin, sub outside IDLE; latched operands not affected by input changes during RUN.
REQ-026 SHALL leave sum, cout, ovf holding the last result in IDLE until the next operation overwrites bits.
REQ-027 SHALL ignore cin when sub = 1.
REQ-028 SHALL use a bit index counter of $clog2(WIDTH) bits with no wrap beyond WIDTH-1.

Reset
REQ-029 SHALL, while rst_n low, force state IDLE, index 0, carry 0, sum 0, cout 0, ovf 0, out_valid 0, busy 0, in_ready 1, independent of clk.
REQ-030 SHALL abort any operation in RUN or DONE on reset with no partial result retained.
REQ-031 SHALL accept a new operation on the first rising edge after rst_n deasserts if in_valid high.

Verification (WIDTH = 8)
REQ-032 SHALL test add a=0x5A b=0x3C cin=0 -> sum=0x96 cout=0 ovf=1, out_valid exactly 8 cycles after accept.
REQ-033 SHALL test add a=0xFF b=0x01 cin=0 -> sum=0x00 cout=1 ovf=0; and a=0x00 b=0x00 cin=1 -> sum=0x01 cout=0.
REQ-034 SHALL test sub a=0x10 b=0x20 cin=1 -> sum=0xF0 cout=0 ovf=0; sub a=0x80 b=0x01 -> sum=0x7F cout=1 ovf=1.
REQ-035 SHALL test out_ready low 5 cycles in DONE -> sum/cout/ovf/out_valid stable, in_ready 0; out_ready high -> IDLE next cycle.
REQ-036 SHALL test rst_n low mid-RUN (after bit 3) -> all outputs reset values immediately, in_ready 1, busy 0; next op result correct.
REQ-037 SHALL test in_valid toggling with changing a/b during RUN -> result reflects only operands latched at acceptance.
